// File: rtl/coretest_arbiter.sv
// coretest_arbiter
//   Two-port round-robin arbiter in front of the 32-bit core register
//   interface. Each granted access drives core_cs for exactly one cycle.
//   The read data and error from that cycle are registered into the
//   winner's rdata/err. The winner's ack is pulsed for one cycle after that.
//   Sequence: IDLE -> ACCESS -> ACK -> IDLE, so one access completes every
//   three cycles.
//
// Ports
//   clk, reset_n                     clock, asynchronous active-low reset
//   req0/1, we0/1, addr0/1, wdata0/1 requester side, sampled on the grant edge
//   ack0/1, rdata0/1, err0/1         completion pulse and held response
//   core_cs, core_we, core_address,
//   core_write_data                  registered core request
//   core_read_data, core_error       core response, combinational while core_cs=1
`timescale 1ns/1ps
module coretest_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  err0,
  output logic                  err1,
  output logic                  core_cs,
  output logic                  core_we,
  output logic [ADDR_WIDTH-1:0] core_address,
  output logic [DATA_WIDTH-1:0] core_write_data,
  input  logic [DATA_WIDTH-1:0] core_read_data,
  input  logic                  core_error
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  state_next_s;
  logic                    last_grant_r;
  logic                    grant_port_r;
  logic                    grant_valid_s;
  logic                    grant_sel_s;
  logic                    sel_we_s;
  logic [ADDR_WIDTH-1:0]   sel_addr_s;
  logic [DATA_WIDTH-1:0]   sel_wdata_s;
  logic [DATA_WIDTH-1:0]   resp_data_s;

  // Arbitration decision and next-state logic.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_sel_s   = 1'b0;
    state_next_s  = state_r;
    case (state_r)
      IDLE: begin
        if (req0 && req1) begin
          // On a tie the port that was not served last time wins.
          grant_valid_s = 1'b1;
          grant_sel_s   = ~last_grant_r;
        end else if (req0) begin
          grant_valid_s = 1'b1;
          grant_sel_s   = 1'b0;
        end else if (req1) begin
          grant_valid_s = 1'b1;
          grant_sel_s   = 1'b1;
        end else begin
          grant_valid_s = 1'b0;
          grant_sel_s   = 1'b0;
        end
        if (req0 || req1) begin
          state_next_s = ACCESS;
        end else begin
          state_next_s = IDLE;
        end
      end
      ACCESS:  state_next_s = ACK;
      ACK:     state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Request fields of the selected port, plus the read response to capture.
  always_comb begin
    if (grant_sel_s) begin
      sel_we_s    = we1;
      sel_addr_s  = addr1;
      sel_wdata_s = wdata1;
    end else begin
      sel_we_s    = we0;
      sel_addr_s  = addr0;
      sel_wdata_s = wdata0;
    end
    // A write returns zero data; only the error is meaningful.
    if (core_we) begin
      resp_data_s = {DATA_WIDTH{1'b0}};
    end else begin
      resp_data_s = core_read_data;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Core request registers, response capture and ack pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_r    <= 1'b1;
      grant_port_r    <= 1'b0;
      core_cs         <= 1'b0;
      core_we         <= 1'b0;
      core_address    <= {ADDR_WIDTH{1'b0}};
      core_write_data <= {DATA_WIDTH{1'b0}};
      ack0            <= 1'b0;
      ack1            <= 1'b0;
      rdata0          <= {DATA_WIDTH{1'b0}};
      rdata1          <= {DATA_WIDTH{1'b0}};
      err0            <= 1'b0;
      err1            <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_valid_s) begin
            core_cs         <= 1'b1;
            core_we         <= sel_we_s;
            core_address    <= sel_addr_s;
            core_write_data <= sel_wdata_s;
            last_grant_r    <= grant_sel_s;
            grant_port_r    <= grant_sel_s;
          end
        end
        ACCESS: begin
          if (grant_port_r) begin
            rdata1 <= resp_data_s;
            err1   <= core_error;
            ack1   <= 1'b1;
          end else begin
            rdata0 <= resp_data_s;
            err0   <= core_error;
            ack0   <= 1'b1;
          end
          // Address and write data stay put; cs alone qualifies them.
          core_cs <= 1'b0;
          core_we <= 1'b0;
        end
        ACK: begin
          ack0 <= 1'b0;
          ack1 <= 1'b0;
        end
        default: begin
          core_cs <= 1'b0;
          core_we <= 1'b0;
          ack0    <= 1'b0;
          ack1    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coretest_arbiter.sv
// tb_coretest_arbiter
//   Random two-requester traffic against a small core register file.
//   Checks are made at the transaction level: which port wins, when core_cs
//   may fire, the ack timing, and the rdata/err each port holds.
`timescale 1ns/1ps
module tb_coretest_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk;
  logic          reset_n;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, err0, err1;
  logic [DW-1:0] rdata0, rdata1;
  logic          core_cs, core_we;
  logic [AW-1:0] core_address;
  logic [DW-1:0] core_write_data;
  logic [DW-1:0] core_read_data;
  logic          core_error;

  coretest_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .err0(err0), .err1(err1),
    .core_cs(core_cs), .core_we(core_we), .core_address(core_address),
    .core_write_data(core_write_data), .core_read_data(core_read_data),
    .core_error(core_error)
  );

  // Core: register file that is read combinationally and written on the cs edge.
  logic [DW-1:0] core_mem [256];
  logic          err_mask [256];
  assign core_read_data = core_cs ? core_mem[core_address] : 32'h0;
  assign core_error     = core_cs & err_mask[core_address];

  always @(posedge clk) begin
    if (core_cs && core_we) core_mem[core_address] <= core_write_data;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  logic [DW-1:0] model_mem [256];
  bit            pend [2];
  logic          p_we [2];
  logic [AW-1:0] p_addr [2];
  logic [DW-1:0] p_wdata [2];
  logic [DW-1:0] exp_rd [2];
  logic          exp_er [2];
  int            last_m, cur_port;
  logic          cur_we, cur_er;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_wdata, cur_rd;
  bit            prev_cs, prev_ack, prev_pend;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      pend[p]   = 1'b0;
      exp_rd[p] = '0;
      exp_er[p] = 1'b0;
    end
    last_m    = 1;
    cur_port  = 0;
    prev_cs   = 1'b0;
    prev_ack  = 1'b0;
    prev_pend = 1'b0;
  endtask

  // Raise a new random request on port p.
  task automatic issue(input int p);
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    w = 1'($urandom_range(0, 1));
    a = AW'($urandom_range(0, 15));
    d = $urandom;
    pend[p] = 1'b1; p_we[p] = w; p_addr[p] = a; p_wdata[p] = d;
    if (p == 0) begin
      req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
    end else begin
      req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
    end
  endtask

  // After a grant the request fields of the winner must be ignored.
  task automatic scramble(input int p);
    if (p == 0) begin
      we0 = 1'($urandom_range(0, 1)); addr0 = AW'($urandom); wdata0 = $urandom;
    end else begin
      we1 = 1'($urandom_range(0, 1)); addr1 = AW'($urandom); wdata1 = $urandom;
    end
  endtask

  // One clock of checking and stimulus, sampled on the falling edge.
  task automatic step(input bit gen);
    int   acked;
    int   port;
    logic exp_cs;
    @(negedge clk);
    acked  = -1;
    // A new access may start only after a full idle cycle with a pending request.
    exp_cs = prev_pend && !prev_cs && !prev_ack;
    check_value("core_cs", core_cs, exp_cs);
    if (core_cs && exp_cs) begin
      if (pend[0] && pend[1]) port = (last_m == 1) ? 0 : 1;
      else                    port = pend[0] ? 0 : 1;
      last_m    = port;
      cur_port  = port;
      cur_we    = p_we[port];
      cur_addr  = p_addr[port];
      cur_wdata = p_wdata[port];
      cur_rd    = cur_we ? 32'h0 : model_mem[cur_addr];
      cur_er    = err_mask[cur_addr];
      check_value("core_we", core_we, cur_we);
      check_value("core_address", core_address, cur_addr);
      check_value("core_write_data", core_write_data, cur_wdata);
      scramble(port);
    end
    check_value("ack0", ack0, prev_cs && cur_port == 0);
    check_value("ack1", ack1, prev_cs && cur_port == 1);
    if (prev_cs && ((cur_port == 0 && ack0) || (cur_port == 1 && ack1))) begin
      exp_rd[cur_port] = cur_rd;
      exp_er[cur_port] = cur_er;
      if (cur_we) model_mem[cur_addr] = cur_wdata;
      acked = cur_port;
    end
    check_value("rdata0", rdata0, exp_rd[0]);
    check_value("err0", err0, exp_er[0]);
    check_value("rdata1", rdata1, exp_rd[1]);
    check_value("err1", err1, exp_er[1]);
    if (acked == 0) begin pend[0] = 1'b0; req0 = 1'b0; end
    if (acked == 1) begin pend[1] = 1'b0; req1 = 1'b0; end
    prev_cs  = core_cs;
    prev_ack = ack0 | ack1;
    if (gen) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && p != acked && $urandom_range(0, 2) == 0) issue(p);
      end
    end
    prev_pend = pend[0] | pend[1];
  endtask

  initial begin
    bit found;
    for (int i = 0; i < 256; i++) begin
      core_mem[i] = $urandom;
      err_mask[i] = ($urandom_range(0, 3) == 0);
    end
    core_mem[0]  = 32'h63747431;
    err_mask[0]  = 1'b0;
    err_mask[1]  = 1'b0;
    err_mask[7]  = 1'b1;
    for (int i = 0; i < 256; i++) model_mem[i] = core_mem[i];

    reset_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_value("rst_ack0", ack0, 1'b0);
    check_value("rst_ack1", ack1, 1'b0);
    check_value("rst_cs", core_cs, 1'b0);
    check_value("rst_we", core_we, 1'b0);
    check_value("rst_addr", core_address, '0);
    check_value("rst_wdata", core_write_data, '0);
    check_value("rst_rdata0", rdata0, '0);
    check_value("rst_rdata1", rdata1, '0);
    check_value("rst_err0", err0, 1'b0);
    check_value("rst_err1", err1, 1'b0);

    // Both ports request together straight after reset: port 0 must go first.
    reset_n = 1'b1;
    issue(0);
    issue(1);
    prev_pend = 1'b1;
    repeat (400) step(1'b1);

    // Reset in the middle of an access.
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      step(1'b1);
      if (core_cs) found = 1'b1;
    end
    check_value("cs_seen_before_reset", found, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check_value("midrst_cs", core_cs, 1'b0);
    check_value("midrst_we", core_we, 1'b0);
    check_value("midrst_ack0", ack0, 1'b0);
    check_value("midrst_ack1", ack1, 1'b0);
    req0 = 1'b0; req1 = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    issue(0);
    issue(1);
    prev_pend = 1'b1;
    repeat (400) step(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
